fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//   Drain stage placed directly downstream of the team FIFO. Polls the FIFO with one-cycle read
//   strobes and takes each returned word. Serialises the word onto a UART-style line:
//   1 start bit (0), Width data bits LSB first, 1 stop bit (1). Turns the buffered parallel stream
//   into a serial TX pin on the FPGA.
// PARAMETERS
//   Width      8   data word width; must equal the FIFO Width
//   ClkPerBit  16  clk cycles per serial bit (baud divider), >= 2
//   PollGap    4   idle cycles after an empty read before the next read strobe, >= 1
// PORTS
//   clk         in   1      single clock; all logic on posedge clk
//   rst         in   1      synchronous, active-high reset
//   en          in   1      1 = fetch and send words; 0 = finish current frame, then idle
//   fifo_data   in   Width  FIFO DataO; valid only in the cycle after fifo_r, and only if fifo_ef=0
//   fifo_ef     in   1      FIFO EF; sampled only in the cycle after fifo_r
//   fifo_r      out  1      FIFO R; registered; high for exactly one cycle per request
//   tx          out  1      serial line; idle high
//   busy        out  1      1 from word load through last stop-bit cycle
//   frame_done  out  1      one-cycle pulse in the cycle after the stop bit ends
// BEHAVIOUR
//   Reset: all outputs are registered. While rst=1 and on the following cycle: tx=1, fifo_r=0,
//     busy=0, frame_done=0, state=IDLE, bit/baud counters=0, shift reg=0.
//   FSM states: IDLE, REQ, WAIT, BACKOFF, START, DATA, STOP.
//     IDLE:    en=1 -> REQ.
//     REQ:     fifo_r=1 for this cycle only -> WAIT.
//     WAIT:    FIFO response is sampled at the end of this cycle.
//              fifo_ef=1 -> BACKOFF (fifo_data ignored; it may be Z).
//              fifo_ef=0 -> latch fifo_data into shift reg, go to START.
//     BACKOFF: counts PollGap cycles, then REQ if en=1, else IDLE.
//     START:   tx=0 for ClkPerBit cycles -> DATA.
//     DATA:    tx=shift[0] for ClkPerBit cycles per bit; shift right each bit.
//              After Width bits -> STOP.
//     STOP:    tx=1 for ClkPerBit cycles. Then pulse frame_done, and go to REQ if en=1, else IDLE.
//   Latency: fifo_r high in cycle c -> tx falls in cycle c+2. A frame is exactly
//     (Width+2)*ClkPerBit cycles of tx. Back-to-back frames have exactly 2 tx-high gap cycles (REQ, WAIT).
//   Polling on empty: one fifo_r pulse every PollGap+2 cycles while en=1. tx stays 1.
//   Handshake rules:
//     - Never more than one outstanding read.
//     - fifo_r is never asserted in WAIT, START, DATA or STOP.
//     - The block never drives a FIFO write.
//   Counters:
//     - Baud counter is $clog2(ClkPerBit) bits, wraps ClkPerBit-1 -> 0.
//     - Bit counter is $clog2(Width+1) bits.
//     - No counter may overflow into the next state.
//   en deasserted mid-frame: frame completes unchanged; no further fifo_r.
//     en reasserted in IDLE -> REQ next cycle.
//   en deasserted in REQ or WAIT: read completes. A fetched word is still sent.
//   rst mid-frame: frame aborted; tx=1 the next cycle. A word already read from the FIFO is lost (by design).
//   fifo_ef and fifo_data are ignored outside WAIT.
// STRUCTURE
//   Shared package fifo_uart_pkg:
//     - FSM state encodings (3-bit localparams).
//     - START_BIT=0, STOP_BIT=1, frame-length function (Width+2).
//   One sub-module, baud_tick_gen:
//     - ClkPerBit counter with synchronous clear.
//     - Emits a one-cycle tick on the last cycle of each bit.
//     - Cleared on every state change.
// TESTING (Width=8, ClkPerBit=4, PollGap=2; bench FIFO model matches team FIFO read timing)
//   1. rst=1 for 3 cycles with en=1 -> tx=1, fifo_r=0, busy=0, frame_done=0 throughout
//      and 1 cycle after release.
//   2. FIFO holds 0xA5, en=1 -> one fifo_r pulse. tx sequence, 4 cycles each:
//      0 | 1,0,1,0,0,1,0,1 | 1.
//      40 tx cycles total; frame_done pulses once.
//   3. FIFO empty, en=1 for 20 cycles -> fifo_r pulses every 4 cycles (5 pulses); tx=1; busy=0.
//   4. FIFO holds 0x00 then 0xFF -> two frames separated by exactly 2 tx-high cycles.
//      Second fifo_r occurs the cycle after the first stop bit ends.
//   5. en dropped during data bit 3 of 0x3C -> frame completes bit-exact; no fifo_r afterward.
//      en=1 again -> fifo_r the next cycle.
//   6. rst asserted during data bit 5 -> tx=1 and busy=0 the next cycle.
//      After release, no fifo_r until en=1 is seen in IDLE.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
// FSM state codes, serial line bit levels and the frame-length helper.
// Imported by the transmitter top level.
package fifo_uart_pkg;

    // Raw 3-bit state codes, kept visible so waveforms can be decoded by hand
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_BACKOFF = 3'd3;
    localparam logic [2:0] ST_START   = 3'd4;
    localparam logic [2:0] ST_DATA    = 3'd5;
    localparam logic [2:0] ST_STOP    = 3'd6;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        REQ     = ST_REQ,
        WAIT    = ST_WAIT,
        BACKOFF = ST_BACKOFF,
        START   = ST_START,
        DATA    = ST_DATA,
        STOP    = ST_STOP
    } state_t;

    // Line levels for the framing bits
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Serial bits per frame: start + data + stop
    function automatic int frame_bits(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Baud divider: one-cycle tick on the last clk of every serial bit period.
// Latency: tick is combinational from the counter; count restarts the cycle after clr.
// No backpressure; clr restarts the bit period whenever the owner changes state.
module baud_tick_gen #(
    parameter int ClkPerBit = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(ClkPerBit);
    localparam logic [CW-1:0] LAST = CW'(ClkPerBit - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // Count clk cycles within a bit, wrapping at the last cycle of the bit
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a FIFO with single read strobes and sends each word as a start/data(LSB first)/stop frame.
// Latency: fifo_r in cycle c -> start bit on tx in cycle c+2; frame is (Width+2)*ClkPerBit cycles.
// At most one read outstanding; empty reads back off PollGap cycles; en low lets the frame finish.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int Width     = 8,
    parameter int ClkPerBit = 16,
    parameter int PollGap   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [Width-1:0] fifo_data,
    input  logic             fifo_ef,
    output logic             fifo_r,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);
    localparam int BW = $clog2(Width + 1);
    localparam int GW = $clog2(PollGap + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(Width - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'(PollGap - 1);

    state_t           state;
    state_t           state_nxt;
    logic [Width-1:0] shift;
    logic [Width-1:0] shift_nxt;
    logic [BW-1:0]    bit_cnt;
    logic [BW-1:0]    bit_cnt_nxt;
    logic [GW-1:0]    gap_cnt;
    logic [GW-1:0]    gap_cnt_nxt;
    logic             tick;
    logic             baud_clr;
    logic             tx_nxt;
    logic             fifo_r_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    // Every state change starts a fresh bit period
    assign baud_clr = (state_nxt != state);

    baud_tick_gen #(
        .ClkPerBit(ClkPerBit)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (baud_clr),
        .tick (tick)
    );

    // Next-state, datapath updates and the next value of every registered output
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        gap_cnt_nxt = gap_cnt;
        done_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                if (en) state_nxt = REQ;
            end
            REQ: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                // FIFO answers in this cycle; data is only meaningful when not empty
                if (fifo_ef) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = BACKOFF;
                end else begin
                    shift_nxt   = fifo_data;
                    bit_cnt_nxt = '0;
                    state_nxt   = START;
                end
            end
            BACKOFF: begin
                if (gap_cnt == LAST_GAP) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = en ? REQ : IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + GW'(1);
                end
            end
            START: begin
                if (tick) state_nxt = DATA;
            end
            DATA: begin
                if (tick) begin
                    shift_nxt = shift >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    done_nxt  = 1'b1;
                    state_nxt = en ? REQ : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from where the FSM is going
        fifo_r_nxt = (state_nxt == REQ);
        busy_nxt   = (state_nxt == START) || (state_nxt == DATA) || (state_nxt == STOP);
        if (state_nxt == START) begin
            tx_nxt = START_BIT;
        end else if (state_nxt == DATA) begin
            tx_nxt = shift_nxt[0];
        end else begin
            tx_nxt = STOP_BIT;
        end
    end

    // State, datapath and output registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            tx         <= STOP_BIT;
            fifo_r     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift      <= shift_nxt;
            bit_cnt    <= bit_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            tx         <= tx_nxt;
            fifo_r     <= fifo_r_nxt;
            busy       <= busy_nxt;
            frame_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, event-level reference model and directed + random stimulus.
// Reference predicts each cycle's {tx, fifo_r, busy, frame_done} from read/frame events.
// Directed scenarios add counted checks on pulses, low-bit counts and inter-frame gaps.
module tb_fifo_uart_tx;
    localparam int W     = 8;
    localparam int CPB   = 4;
    localparam int PG    = 2;
    localparam int FRAME = (W + 2) * CPB;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] fifo_data;
    logic         fifo_ef;
    logic         fifo_r;
    logic         tx;
    logic         busy;
    logic         frame_done;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    logic [W-1:0] fq[$];

    fifo_uart_tx #(
        .Width     (W),
        .ClkPerBit (CPB),
        .PollGap   (PG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_data  (fifo_data),
        .fifo_ef    (fifo_ef),
        .fifo_r     (fifo_r),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // FIFO model: answers a read strobe in the following cycle; junk on the bus otherwise
    always @(posedge clk) begin
        bit rd;
        rd = fifo_r;
        #1;
        if (rd) begin
            if (fq.size() > 0) begin
                fifo_ef   = 1'b0;
                fifo_data = fq.pop_front();
            end else begin
                fifo_ef   = 1'b1;
                fifo_data = W'($urandom);
            end
        end else begin
            fifo_ef   = 1'($urandom);
            fifo_data = W'($urandom);
        end
    end

    // Expected line level at offset off into a frame carrying word w
    function automatic logic exp_tx(input int off, input logic [W-1:0] w);
        int b;
        b = off / CPB;
        if (b == 0) return 1'b0;
        if (b <= W) return w[b-1];
        return 1'b1;
    endfunction

    // Reference model state (cycle numbers of predicted events)
    bit           idle        = 1'b1;
    int           due         = -1;
    int           resp_at     = -1;
    int           backoff_end = -1;
    bit           fr_on       = 1'b0;
    int           fr_start    = 0;
    logic [W-1:0] fr_word     = '0;
    int           done_at     = -1;

    // Statistics used by the directed scenarios
    int  cnt_r = 0, cnt_done = 0, cnt_busy = 0, cnt_low = 0;
    int  busy_fall = 0, last_gap = -1;
    bit  prev_busy = 1'b0;

    always @(negedge clk) begin
        logic [3:0] exp;
        bit in_frame;
        in_frame = fr_on && (cyc >= fr_start) && (cyc < fr_start + FRAME);
        exp[3] = in_frame ? exp_tx(cyc - fr_start, fr_word) : 1'b1;
        exp[2] = (cyc == due);
        exp[1] = in_frame;
        exp[0] = (cyc == done_at);
        check("outputs{tx,r,busy,done}", 32'({tx, fifo_r, busy, frame_done}), 32'(exp));

        if (fifo_r)     cnt_r++;
        if (frame_done) cnt_done++;
        if (busy)       cnt_busy++;
        if (!tx)        cnt_low++;
        if (busy && !prev_busy) last_gap = cyc - busy_fall;
        if (!busy && prev_busy) busy_fall = cyc;
        prev_busy = busy;

        if (rst) begin
            idle        = 1'b1;
            due         = -1;
            resp_at     = -1;
            backoff_end = -1;
            fr_on       = 1'b0;
            done_at     = -1;
        end else begin
            if (cyc == due) resp_at = cyc + 1;
            if (idle && en) begin
                due  = cyc + 1;
                idle = 1'b0;
            end
            if (cyc == resp_at) begin
                if (fifo_ef) begin
                    backoff_end = cyc + PG;
                end else begin
                    fr_on    = 1'b1;
                    fr_start = cyc + 1;
                    fr_word  = fifo_data;
                    done_at  = cyc + 1 + FRAME;
                end
            end
            if (cyc == backoff_end) begin
                if (en) due = cyc + 1;
                else    idle = 1'b1;
            end
            if (fr_on && cyc == fr_start + FRAME - 1) begin
                if (en) due = cyc + 1;
                else    idle = 1'b1;
            end
        end
        cyc++;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        int s_r, s_done, s_busy, s_low;
        rst       = 1'b1;
        en        = 1'b1;
        fifo_ef   = 1'b1;
        fifo_data = '0;

        // Reset held three cycles with en high, then the first post-release cycle stays idle
        cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_outputs", 32'({tx, fifo_r, busy, frame_done}), 32'b1000);

        // Empty FIFO polling: five strobes in any 20-cycle window, line quiet
        cycles(6);
        s_r = cnt_r; s_busy = cnt_busy; s_low = cnt_low;
        cycles(20);
        check("poll_strobes", 32'(cnt_r - s_r), 32'd5);
        check("poll_busy", 32'(cnt_busy - s_busy), 32'd0);
        check("poll_tx_low", 32'(cnt_low - s_low), 32'd0);

        // Single word 0xA5: 4 zero data bits + start bit low
        s_done = cnt_done; s_busy = cnt_busy; s_low = cnt_low;
        fq.push_back(8'hA5);
        cycles(60);
        check("a5_done", 32'(cnt_done - s_done), 32'd1);
        check("a5_busy", 32'(cnt_busy - s_busy), 32'd40);
        check("a5_tx_low", 32'(cnt_low - s_low), 32'd20);

        // Back-to-back 0x00, 0xFF with a two-cycle gap between frames
        s_done = cnt_done; s_busy = cnt_busy; s_low = cnt_low;
        fq.push_back(8'h00);
        fq.push_back(8'hFF);
        cycles(100);
        check("b2b_done", 32'(cnt_done - s_done), 32'd2);
        check("b2b_busy", 32'(cnt_busy - s_busy), 32'd80);
        check("b2b_tx_low", 32'(cnt_low - s_low), 32'd40);
        check("b2b_gap", 32'(last_gap), 32'd2);

        // 0x3C with en dropped during data bit 3
        fq.push_back(8'h3C);
        wait_busy("3c_start_timeout");
        s_done = cnt_done; s_low = cnt_low; s_r = cnt_r;
        cycles(17);
        en = 1'b0;
        cycles(60);
        check("3c_done", 32'(cnt_done - s_done), 32'd1);
        check("3c_tx_low", 32'(cnt_low - s_low), 32'd20);
        check("3c_no_read", 32'(cnt_r - s_r), 32'd0);
        en = 1'b1;
        @(negedge clk);
        check("3c_reen_same", 32'(fifo_r), 32'd0);
        @(negedge clk);
        check("3c_reen_next", 32'(fifo_r), 32'd1);

        // Reset during data bit 5 of 0x5A
        cycles(1);
        fq.push_back(8'h5A);
        wait_busy("5a_start_timeout");
        cycles(25);
        rst = 1'b1;
        en  = 1'b0;
        cycles(1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        s_r = cnt_r;
        cycles(8);
        check("rst_no_read", 32'(cnt_r - s_r), 32'd0);
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_reen_read", 32'(fifo_r), 32'd1);

        // Randomised traffic, enable toggling and occasional resets
        for (int i = 0; i < 300; i++) begin
            int act;
            act = $urandom_range(0, 9);
            if (act < 3) begin
                fq.push_back(W'($urandom));
            end else if (act < 7) begin
                en = ($urandom_range(0, 3) != 0);
            end else if (act == 7 && $urandom_range(0, 3) == 0) begin
                rst = 1'b1;
                cycles($urandom_range(1, 2));
                rst = 1'b0;
            end
            cycles($urandom_range(1, 50));
        end
        en = 1'b1;
        cycles(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
